multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 160 ++++++++++++++++
 tb/tb_multicycle_control.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle processor control unit.
// Sequences each instruction through fetch, decode and the opcode-specific
// execute/memory/writeback states, owns the program counter, and keeps
// retired-instruction and active-cycle counters. Running past the end of
// instruction memory parks the machine in HALT until reset.
//
// state      | meaning
// -----------+--------------------------------------------------
// FETCH      | latch pc into pc_prev, advance pc, fetch enabled
// DECODE     | dispatch on opcode; unknown opcode ends here
// MEM_ADDR   | compute load/store address (alu_src, add)
// MEM_READ   | data memory read
// WB_MEM     | write loaded data to register file (final)
// MEM_WRITE  | data memory write (final)
// EXEC_R     | R-type ALU operation
// EXEC_I     | I-type ALU operation
// WB_R       | write ALU result to register file (final)
// BRANCH     | compare; on zero redirect pc to pc_prev + imm (final)
// HALT       | pc past end of program, absorbing until reset

module multicycle_control #(
    parameter int N_INSTR = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic [31:0] imm,
    output logic [3:0]  state,
    output logic [31:0] pc,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic [1:0]  alu_op,
    output logic        halt,
    output logic [15:0] retired,
    output logic [31:0] cycles
);

    localparam logic [3:0] S_FETCH     = 4'b0000;
    localparam logic [3:0] S_DECODE    = 4'b0001;
    localparam logic [3:0] S_MEM_ADDR  = 4'b0010;
    localparam logic [3:0] S_MEM_READ  = 4'b0011;
    localparam logic [3:0] S_WB_MEM    = 4'b0100;
    localparam logic [3:0] S_MEM_WRITE = 4'b0101;
    localparam logic [3:0] S_EXEC_R    = 4'b0110;
    localparam logic [3:0] S_WB_R      = 4'b0111;
    localparam logic [3:0] S_BRANCH    = 4'b1000;
    localparam logic [3:0] S_EXEC_I    = 4'b1001;
    localparam logic [3:0] S_HALT      = 4'b1111;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [31:0] PC_LIMIT = 32'(N_INSTR);

    logic [3:0]  state_next;
    logic [31:0] pc_prev;
    logic [31:0] pc_branch;
    logic        branch_taken;
    logic [31:0] pc_upd;
    logic [3:0]  end_next;
    logic        retire;

    // PC as it will be after this cycle; decides HALT vs FETCH at instruction end
    always_comb begin
        pc_branch    = pc_prev + imm;
        branch_taken = (state == S_BRANCH) && zero;
        pc_upd       = branch_taken ? pc_branch : pc;
        end_next     = (pc_upd >= PC_LIMIT) ? S_HALT : S_FETCH;
        retire       = (state == S_WB_MEM) || (state == S_WB_R) ||
                       (state == S_MEM_WRITE) || (state == S_BRANCH);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:     state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:               state_next = S_EXEC_R;
                    OP_I:               state_next = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_next = S_MEM_ADDR;
                    OP_BRANCH:          state_next = S_BRANCH;
                    default:            state_next = end_next;
                endcase
            end
            S_MEM_ADDR:  state_next = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_next = S_WB_MEM;
            S_EXEC_R:    state_next = S_WB_R;
            S_EXEC_I:    state_next = S_WB_R;
            S_WB_MEM,
            S_WB_R,
            S_MEM_WRITE,
            S_BRANCH:    state_next = end_next;
            S_HALT:      state_next = S_HALT;
            default:     state_next = S_FETCH;
        endcase
    end

    // Moore datapath controls decoded from the current state
    always_comb begin
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = 2'b00;
        halt       = 1'b0;
        case (state)
            S_MEM_ADDR:  begin alu_src = 1'b1; alu_op = 2'b00; end
            S_MEM_READ:  mem_read = 1'b1;
            S_WB_MEM:    begin reg_write = 1'b1; mem_to_reg = 1'b1; end
            S_MEM_WRITE: mem_write = 1'b1;
            S_EXEC_R:    alu_op = 2'b10;
            S_EXEC_I:    begin alu_src = 1'b1; alu_op = 2'b11; end
            S_WB_R:      reg_write = 1'b1;
            S_BRANCH:    alu_op = 2'b01;
            S_HALT:      halt = 1'b1;
            default:     ;
        endcase
    end

    // PC, branch base and counters; everything freezes in HALT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= 32'd0;
            pc_prev <= 32'd0;
            retired <= 16'd0;
            cycles  <= 32'd0;
        end else if (state != S_HALT) begin
            cycles <= cycles + 32'd1;
            if (state == S_FETCH) begin
                pc_prev <= pc;
                pc      <= pc + 32'd1;
            end else if (branch_taken) begin
                pc <= pc_branch;
            end
            if (retire) begin
                retired <= retired + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control. Stimulus pushes the hand-derived
// per-cycle expectations into a queue; the monitor pops one entry on every
// falling edge (or on an explicit mid-cycle sample request) and compares.

module tb_multicycle_control;

    typedef struct packed {
        logic [7:0]  tag;
        logic [3:0]  st;
        logic [31:0] pc;
        logic [15:0] ret;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic        zero = 1'b0;
    logic [31:0] imm = 32'd0;

    logic [3:0]  state_a, state_b;
    logic [31:0] pc_a, pc_b, cycles_a, cycles_b;
    logic [15:0] retired_a, retired_b;
    logic        rw_a, mr_a, mw_a, as_a, m2r_a, halt_a;
    logic        rw_b, mr_b, mw_b, as_b, m2r_b, halt_b;
    logic [1:0]  aop_a, aop_b;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .imm(imm),
        .state(state_a), .pc(pc_a), .reg_write(rw_a), .mem_read(mr_a),
        .mem_write(mw_a), .alu_src(as_a), .mem_to_reg(m2r_a), .alu_op(aop_a),
        .halt(halt_a), .retired(retired_a), .cycles(cycles_a)
    );

    multicycle_control #(.N_INSTR(3)) dut3 (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .imm(imm),
        .state(state_b), .pc(pc_b), .reg_write(rw_b), .mem_read(mr_b),
        .mem_write(mw_b), .alu_src(as_b), .mem_to_reg(m2r_b), .alu_op(aop_b),
        .halt(halt_b), .retired(retired_b), .cycles(cycles_b)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic sel = 1'b0;
    int   case_id = 0;
    event force_chk;

    // control vector {reg_write, mem_read, mem_write, alu_src, mem_to_reg, alu_op}
    function automatic logic [6:0] ctrl_of(input logic [3:0] st);
        case (st)
            4'd2:    return 7'b0001000;
            4'd3:    return 7'b0100000;
            4'd4:    return 7'b1000100;
            4'd5:    return 7'b0010000;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1000000;
            4'd8:    return 7'b0000001;
            4'd9:    return 7'b0001011;
            default: return 7'b0000000;
        endcase
    endfunction

    logic [3:0]  a_st;
    logic [31:0] a_pc, a_cyc;
    logic [15:0] a_ret;
    logic [6:0]  a_ctrl;
    logic        a_halt;

    assign a_st   = sel ? state_b : state_a;
    assign a_pc   = sel ? pc_b : pc_a;
    assign a_cyc  = sel ? cycles_b : cycles_a;
    assign a_ret  = sel ? retired_b : retired_a;
    assign a_ctrl = sel ? {rw_b, mr_b, mw_b, as_b, m2r_b, aop_b}
                        : {rw_a, mr_a, mw_a, as_a, m2r_a, aop_a};
    assign a_halt = sel ? halt_b : halt_a;

    exp_t       e;
    logic [6:0] e_ctrl;
    logic       e_halt;

    // Monitor: pop and compare whenever a sample point arrives with work queued
    initial begin
        forever begin
            @(negedge clk or force_chk);
            if (q.size() > 0) begin
                e = q.pop_front();
                e_ctrl = ctrl_of(e.st);
                e_halt = (e.st == 4'hF);
                vectors++;
                if (a_st !== e.st || a_pc !== e.pc || a_ret !== e.ret ||
                    a_cyc !== e.cyc || a_ctrl !== e_ctrl || a_halt !== e_halt) begin
                    miscompares++;
                    $display("FAIL case%0d vec%0d: got st=%h pc=%0d ret=%0d cyc=%0d ctrl=%b halt=%b, want st=%h pc=%0d ret=%0d cyc=%0d ctrl=%b halt=%b",
                             e.tag, vectors, a_st, a_pc, a_ret, a_cyc, a_ctrl, a_halt,
                             e.st, e.pc, e.ret, e.cyc, e_ctrl, e_halt);
                end
            end
        end
    end

    task automatic push(input logic [3:0] st, input logic [31:0] pcv,
                        input logic [15:0] ret, input logic [31:0] cyc);
        exp_t x;
        x.tag = 8'(case_id);
        x.st  = st;
        x.pc  = pcv;
        x.ret = ret;
        x.cyc = cyc;
        q.push_back(x);
    endtask

    // Hold reset across one rising edge, then release just after the next one
    task automatic start_case(input int id, input logic s, input logic [6:0] op);
        @(posedge clk);
        #2 reset = 1'b1;
        case_id = id;
        sel = s;
        opcode = op;
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL case%0d timeout: %0d expected vectors never observed", case_id, q.size());
            q.delete();
        end
    endtask

    task automatic push_unknown_run(input int last_k);
        for (int k = 0; k <= last_k; k++)
            push((k % 2 == 1) ? 4'd1 : 4'd0, 32'((k + 1) / 2), 16'd0, 32'(k));
    endtask

    initial begin
        logic [3:0] rseq [4];
        rseq[0] = 4'd0; rseq[1] = 4'd1; rseq[2] = 4'd6; rseq[3] = 4'd7;

        // R-type: 0,1,6,7,0
        start_case(1, 1'b0, 7'b0110011);
        push(0, 0, 0, 0); push(1, 1, 0, 1); push(6, 1, 0, 2);
        push(7, 1, 0, 3); push(0, 1, 1, 4); push(1, 2, 1, 5);
        drain();

        // I-type: 0,1,9,7,0
        start_case(2, 1'b0, 7'b0010011);
        push(0, 0, 0, 0); push(1, 1, 0, 1); push(9, 1, 0, 2);
        push(7, 1, 0, 3); push(0, 1, 1, 4); push(1, 2, 1, 5);
        drain();

        // load: 0,1,2,3,4,0
        start_case(3, 1'b0, 7'b0000011);
        push(0, 0, 0, 0); push(1, 1, 0, 1); push(2, 1, 0, 2);
        push(3, 1, 0, 3); push(4, 1, 0, 4); push(0, 1, 1, 5);
        drain();

        // store: 0,1,2,5,0
        start_case(4, 1'b0, 7'b0100011);
        push(0, 0, 0, 0); push(1, 1, 0, 1); push(2, 1, 0, 2);
        push(5, 1, 0, 3); push(0, 1, 1, 4);
        drain();

        // unknown opcode: 0,1,0,1 with pc stepping and no retire
        start_case(5, 1'b0, 7'b1111111);
        push_unknown_run(4);
        drain();

        // reach pc=4 with unknown opcodes, then a taken branch by -2
        start_case(6, 1'b0, 7'b1111111);
        imm = 32'hFFFF_FFFE;
        zero = 1'b1;
        push_unknown_run(8);
        push(1, 5, 0, 9); push(8, 5, 0, 10); push(0, 2, 1, 11); push(1, 3, 1, 12);
        repeat (8) @(posedge clk);
        #2 opcode = 7'b1100011;
        drain();

        // same branch, not taken
        start_case(7, 1'b0, 7'b1111111);
        zero = 1'b0;
        push_unknown_run(8);
        push(1, 5, 0, 9); push(8, 5, 0, 10); push(0, 5, 1, 11); push(1, 6, 1, 12);
        repeat (8) @(posedge clk);
        #2 opcode = 7'b1100011;
        drain();

        // asynchronous reset while in MEM_READ, then held across an edge
        start_case(8, 1'b0, 7'b0000011);
        zero = 1'b0;
        push(0, 0, 0, 0); push(1, 1, 0, 1); push(2, 1, 0, 2);
        repeat (3) @(posedge clk);
        #1 push(3, 1, 0, 3);
        -> force_chk;
        #1 reset = 1'b1;
        #1 push(0, 0, 0, 0);
        -> force_chk;
        @(posedge clk);
        #2 push(0, 0, 0, 0);
        drain();

        // N_INSTR=3 instance: three R-type instructions then HALT, stable
        start_case(9, 1'b1, 7'b0110011);
        for (int k = 0; k < 12; k++)
            push(rseq[k % 4], 32'(k / 4 + ((k % 4) > 0 ? 1 : 0)), 16'(k / 4), 32'(k));
        for (int k = 12; k <= 22; k++)
            push(4'hF, 32'd3, 16'd3, 32'd12);
        drain();

        // reset from HALT clears everything between edges, then restart
        #2 reset = 1'b1;
        #1 push(0, 0, 0, 0);
        -> force_chk;
        @(posedge clk);
        #2 reset = 1'b0;
        push(0, 0, 0, 0); push(1, 1, 0, 1); push(6, 1, 0, 2);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
